// File: rtl/multi_logger.sv
// Multi-channel line logger: round-robin admission of fixed-length lines into an
// external single-port RAM FIFO, drained byte-serially to a strobe/busy sink.
module multi_logger #(
  parameter int CHANNELS = 2,
  parameter int COUNT    = 8,
  parameter int AW       = 11,
  parameter int PREFIX   = 1,
  parameter int EOL      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*COUNT*8-1:0]  text,
  input  logic [CHANNELS-1:0]          stb,
  output logic [CHANNELS-1:0]          busy,
  output logic                         full,
  output logic                         empty,
  output logic [15:0]                  drop_count,
  output logic                         ext_stb,
  output logic [7:0]                   ext_data,
  input  logic                         ext_busy,
  output logic [AW-1:0]                mem_addr_w,
  output logic [AW-1:0]                mem_addr_r,
  output logic                         mem_rw,
  output logic [7:0]                   mem_data_in,
  input  logic [7:0]                   mem_data_out
);

  localparam int DEPTH = 2 ** AW;
  localparam int L     = COUNT + 2*PREFIX + 2*EOL;
  localparam int GW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW    = $clog2(L + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_C     = (AW+1)'(L);

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_SEND, R_HOLD} rstate_e;

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic [COUNT*8-1:0]    hold_q [CHANNELS];
  logic [CHANNELS-1:0]   busy_q, busy_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         wgrant_q, wgrant_d;
  logic [IW-1:0]         widx_q, widx_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  full_q, empty_q;
  logic [15:0]           drop_q, drop_d;
  logic                  ext_stb_q, ext_stb_d;
  logic [7:0]            ext_data_q, ext_data_d;
  logic                  lat_q, hwait_q;
  logic                  grant_valid, w_done, room;
  logic [GW-1:0]         grant_idx, cand;
  logic [7:0]            wr_byte;
  logic [COUNT*8-1:0]    sel_text;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q     <= W_IDLE;
      rstate_q     <= R_IDLE;
      busy_q       <= '0;
      last_grant_q <= GW'(CHANNELS - 1);
      wgrant_q     <= '0;
      widx_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      drop_q       <= '0;
      ext_stb_q    <= 1'b0;
      ext_data_q   <= '0;
      lat_q        <= 1'b0;
      hwait_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      wgrant_q     <= wgrant_d;
      widx_q       <= widx_d;
      wr_ptr_q     <= (wstate_q == W_WRITE) ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q     <= (rstate_q == R_READ) ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q      <= count_d;
      full_q       <= (DEPTH_C - count_q) < L_C;
      empty_q      <= (count_q == '0);
      drop_q       <= drop_d;
      ext_stb_q    <= ext_stb_d;
      ext_data_q   <= ext_data_d;
      lat_q        <= (rstate_q == R_SEND);
      hwait_q      <= (rstate_q == R_HOLD);
      for (int i = 0; i < CHANNELS; i++)
        if (stb[i] && !busy_q[i]) hold_q[i] <= text[i*COUNT*8 +: COUNT*8];
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      cand = GW'((int'(last_grant_q) + 1 + off) % CHANNELS);
      if (!grant_valid && busy_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign room   = (DEPTH_C - count_q) >= L_C;
  assign w_done = ((wstate_q == W_WRITE) && (widx_q == IW'(L - 1))) || (wstate_q == W_DROP);

  always_comb begin
    wstate_d     = wstate_q;
    wgrant_d     = wgrant_q;
    widx_d       = widx_q;
    last_grant_d = last_grant_q;
    case (wstate_q)
      W_IDLE: if (grant_valid) begin
        wgrant_d     = grant_idx;
        last_grant_d = grant_idx;
        widx_d       = '0;
        wstate_d     = room ? W_WRITE : W_DROP;
      end
      W_WRITE: begin
        if (widx_q == IW'(L - 1)) wstate_d = W_IDLE;
        else                      widx_d   = widx_q + 1'b1;
      end
      W_DROP:  wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reader never overlaps a write cycle, including one the writer enters next.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: if (count_q != '0 && wstate_q != W_WRITE && wstate_d != W_WRITE)
                rstate_d = R_READ;
      R_READ: rstate_d = R_SEND;
      R_SEND: if (!ext_busy) rstate_d = R_HOLD;
      R_HOLD: if (hwait_q && !ext_busy) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < CHANNELS; i++)
      if (stb[i] && !busy_q[i]) busy_d[i] = 1'b1;
    if (w_done) busy_d[wgrant_q] = 1'b0;

    count_d = count_q;
    if (wstate_q == W_WRITE)     count_d = count_q + 1'b1;
    else if (rstate_q == R_READ) count_d = count_q - 1'b1;

    drop_d = drop_q;
    if (wstate_q == W_DROP && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;

    ext_stb_d  = (rstate_q == R_SEND) && !ext_busy;
    ext_data_d = (rstate_q == R_SEND && !lat_q) ? mem_data_out : ext_data_q;
  end

  always_comb begin
    wr_byte  = '0;
    sel_text = hold_q[wgrant_q];
    if (wstate_q == W_WRITE) begin
      for (int j = 0; j < COUNT; j++)
        if (int'(widx_q) == j + 2*PREFIX) wr_byte = sel_text[(COUNT-1-j)*8 +: 8];
      if (PREFIX != 0) begin
        if (widx_q == IW'(0)) wr_byte = 8'h30 + 8'(wgrant_q);
        if (widx_q == IW'(1)) wr_byte = 8'h3A;
      end
      if (EOL != 0) begin
        if (widx_q == IW'(L - 2)) wr_byte = 8'h0D;
        if (widx_q == IW'(L - 1)) wr_byte = 8'h0A;
      end
    end
  end

  assign busy        = busy_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign drop_count  = drop_q;
  assign ext_stb     = ext_stb_q;
  assign ext_data    = ext_data_q;
  assign mem_addr_w  = wr_ptr_q;
  assign mem_addr_r  = rd_ptr_q;
  assign mem_rw      = (wstate_q != W_WRITE);
  assign mem_data_in = wr_byte;

endmodule

// File: tb/tb_multi_logger.sv
// Directed bench for multi_logger: a large-FIFO instance (a) and a 16-byte FIFO
// instance (b), each with its own RAM model and byte sink.
module tb_multi_logger;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] text_a, text_b;
  logic [1:0]   stb_a, stb_b, busy_a, busy_b;
  logic         full_a, full_b, empty_a, empty_b;
  logic [15:0]  drop_a, drop_b;
  logic         ext_stb_a, ext_stb_b, ext_busy_a, ext_busy_b;
  logic [7:0]   ext_data_a, ext_data_b;
  logic [10:0]  waddr_a, raddr_a;
  logic [3:0]   waddr_b, raddr_b;
  logic         rw_a, rw_b;
  logic [7:0]   din_a, din_b, dout_a, dout_b;

  multi_logger #(.CHANNELS(2), .COUNT(8), .AW(11), .PREFIX(1), .EOL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .text(text_a), .stb(stb_a), .busy(busy_a),
    .full(full_a), .empty(empty_a), .drop_count(drop_a), .ext_stb(ext_stb_a),
    .ext_data(ext_data_a), .ext_busy(ext_busy_a), .mem_addr_w(waddr_a),
    .mem_addr_r(raddr_a), .mem_rw(rw_a), .mem_data_in(din_a), .mem_data_out(dout_a));

  multi_logger #(.CHANNELS(2), .COUNT(8), .AW(4), .PREFIX(1), .EOL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .text(text_b), .stb(stb_b), .busy(busy_b),
    .full(full_b), .empty(empty_b), .drop_count(drop_b), .ext_stb(ext_stb_b),
    .ext_data(ext_data_b), .ext_busy(ext_busy_b), .mem_addr_w(waddr_b),
    .mem_addr_r(raddr_b), .mem_rw(rw_b), .mem_data_in(din_b), .mem_data_out(dout_b));

  logic [7:0] mem_a [2048];
  logic [7:0] mem_b [16];
  always @(posedge clk) begin
    if (!rw_a) mem_a[waddr_a] <= din_a; else dout_a <= mem_a[raddr_a];
    if (!rw_b) mem_b[waddr_b] <= din_b; else dout_b <= mem_b[raddr_b];
  end

  logic [7:0] q_a[$], q_b[$], exp_q[$];
  logic bp_chk = 1'b0;
  int   bp_viol = 0;
  int   checks = 0, errors = 0;

  always @(negedge clk) begin
    if (ext_stb_a) q_a.push_back(ext_data_a);
    if (ext_stb_b) q_b.push_back(ext_data_b);
    if (bp_chk && ext_stb_a) bp_viol <= bp_viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_exp(input int ch, input logic [63:0] t);
    logic [63:0] tmp;
    tmp = t;
    exp_q.push_back(8'h30 + 8'(ch));
    exp_q.push_back(8'h3A);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tmp[63:56]);
      tmp = tmp << 8;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic submit_a(input logic [1:0] m);
    @(negedge clk); stb_a = m;
    @(negedge clk); stb_a = 2'b00;
  endtask

  task automatic submit_b(input logic [1:0] m);
    @(negedge clk); stb_b = m;
    @(negedge clk); stb_b = 2'b00;
  endtask

  task automatic wait_a(input int n, input int budget);
    int k;
    k = 0;
    while (q_a.size() < n && k < budget) begin @(negedge clk); k++; end
  endtask

  task automatic wait_b(input int n, input int budget);
    int k;
    k = 0;
    while (q_b.size() < n && k < budget) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset;
    checks++;
    if ({busy_a, full_a, empty_a, drop_a, ext_stb_a, ext_data_a, rw_a, waddr_a, raddr_a, din_a}
        !== {2'b00, 1'b0, 1'b1, 16'h0, 1'b0, 8'h00, 1'b1, 11'h0, 11'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_a: busy=%b full=%b empty=%b drop=%h stb=%b data=%h rw=%b aw=%h ar=%h din=%h",
               busy_a, full_a, empty_a, drop_a, ext_stb_a, ext_data_a, rw_a, waddr_a, raddr_a, din_a);
    end
    checks++;
    if ({busy_b, full_b, empty_b, drop_b, ext_stb_b, ext_data_b, rw_b, waddr_b, raddr_b, din_b}
        !== {2'b00, 1'b0, 1'b1, 16'h0, 1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 8'h00}) begin
      errors++;
      $display("FAIL reset_b: busy=%b full=%b empty=%b drop=%h stb=%b data=%h rw=%b aw=%h ar=%h din=%h",
               busy_b, full_b, empty_b, drop_b, ext_stb_b, ext_data_b, rw_b, waddr_b, raddr_b, din_b);
    end
  endtask

  task automatic test_single_line;
    int k;
    q_a.delete(); exp_q.delete();
    text_a[63:0] = "HELLO!!!";
    add_exp(0, "HELLO!!!");
    submit_a(2'b01);
    checks++;
    if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL single_busy_set: got %b expected 1", busy_a[0]); end
    @(negedge clk);
    checks++;
    if (rw_a !== 1'b0 || din_a !== 8'h30 || waddr_a !== 11'd0) begin
      errors++;
      $display("FAIL single_first_write: rw=%b din=%h addr=%h expected rw=0 din=30 addr=0", rw_a, din_a, waddr_a);
    end
    k = 0;
    while (busy_a[0] === 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (k !== 12) begin errors++; $display("FAIL single_busy_fall: busy fell %0d cycles after first write, expected 12", k); end
    wait_a(12, 400);
    checks++;
    if (q_a.size() !== exp_q.size()) begin errors++; $display("FAIL single_len: got %0d bytes expected %0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte[%0d]: got %h expected %h", i, q_a[i], exp_q[i]); end
    end
    checks++;
    if (drop_a !== 16'd0) begin errors++; $display("FAIL single_drop: got %0d expected 0", drop_a); end
    repeat (10) @(negedge clk);
    checks++;
    if (empty_a !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty_a); end
  endtask

  task automatic test_simultaneous;
    q_a.delete(); exp_q.delete();
    text_a = {"BBBBBBBB", "AAAAAAAA"};
    add_exp(0, "AAAAAAAA");
    add_exp(1, "BBBBBBBB");
    submit_a(2'b11);
    wait_a(24, 1000);
    text_a[63:0] = "CCCCCCCC";
    add_exp(0, "CCCCCCCC");
    submit_a(2'b01);
    wait_a(36, 1000);
    text_a = {"EEEEEEEE", "DDDDDDDD"};
    add_exp(1, "EEEEEEEE");
    add_exp(0, "DDDDDDDD");
    submit_a(2'b11);
    wait_a(60, 1000);
    checks++;
    if (q_a.size() !== exp_q.size()) begin errors++; $display("FAIL simul_len: got %0d bytes expected %0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_q[i]) begin errors++; $display("FAIL simul_byte[%0d]: got %h expected %h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    q_a.delete(); exp_q.delete();
    text_a[127:64] = "PRESSURE";
    add_exp(1, "PRESSURE");
    submit_a(2'b10);
    wait_a(4, 400);
    ext_busy_a = 1'b1;
    @(negedge clk);
    bp_chk = 1'b1;
    repeat (199) @(negedge clk);
    bp_chk = 1'b0;
    checks++;
    if (bp_viol !== 0) begin errors++; $display("FAIL bp_stb_while_busy: got %0d strobes expected 0", bp_viol); end
    checks++;
    if (q_a.size() !== 4) begin errors++; $display("FAIL bp_held_count: got %0d bytes expected 4", q_a.size()); end
    ext_busy_a = 1'b0;
    wait_a(12, 400);
    repeat (30) @(negedge clk);
    checks++;
    if (q_a.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d bytes expected %0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_write;
    int k;
    q_a.delete(); exp_q.delete();
    text_a[63:0] = "RESETME!";
    submit_a(2'b01);
    k = 0;
    while (rw_a === 1'b1 && k < 10) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    checks++;
    if (rw_a !== 1'b0 || din_a !== 8'h53) begin
      errors++;
      $display("FAIL rst_byte5: rw=%b din=%h expected rw=0 din=53", rw_a, din_a);
    end
    rst_n = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (q_a.size() !== 0) begin errors++; $display("FAIL rst_no_output: got %0d bytes expected 0", q_a.size()); end
    text_a[127:64] = "FRESH123";
    add_exp(1, "FRESH123");
    submit_a(2'b10);
    wait_a(12, 400);
    checks++;
    if (q_a.size() !== exp_q.size()) begin errors++; $display("FAIL rst_fresh_len: got %0d bytes expected %0d", q_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_a.size(); i++) begin
      checks++;
      if (q_a[i] !== exp_q[i]) begin errors++; $display("FAIL rst_fresh_byte[%0d]: got %h expected %h", i, q_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow;
    q_b.delete(); exp_q.delete();
    ext_busy_b = 1'b1;
    text_b = {"YYYYYYYY", "XXXXXXXX"};
    add_exp(0, "XXXXXXXX");
    submit_b(2'b11);
    repeat (40) @(negedge clk);
    checks++;
    if (drop_b !== 16'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_b); end
    checks++;
    if (full_b !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full_b); end
    checks++;
    if (busy_b !== 2'b00 || empty_b !== 1'b0 || q_b.size() !== 0) begin
      errors++;
      $display("FAIL ovf_state: busy=%b empty=%b bytes=%0d expected busy=00 empty=0 bytes=0", busy_b, empty_b, q_b.size());
    end
    submit_b(2'b10);
    checks++;
    if (busy_b[1] !== 1'b1) begin errors++; $display("FAIL drop_busy_t1: got %b expected 1", busy_b[1]); end
    @(negedge clk);
    checks++;
    if (busy_b[1] !== 1'b1) begin errors++; $display("FAIL drop_busy_t2: got %b expected 1", busy_b[1]); end
    @(negedge clk);
    checks++;
    if (busy_b[1] !== 1'b0 || drop_b !== 16'd2) begin
      errors++;
      $display("FAIL drop_busy_t3: busy=%b drop=%0d expected busy=0 drop=2", busy_b[1], drop_b);
    end
    ext_busy_b = 1'b0;
    wait_b(12, 400);
    repeat (60) @(negedge clk);
    checks++;
    if (q_b.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_len: got %0d bytes expected %0d", q_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte[%0d]: got %h expected %h", i, q_b[i], exp_q[i]); end
    end
    checks++;
    if (empty_b !== 1'b1 || full_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: empty=%b full=%b expected empty=1 full=0", empty_b, full_b);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] t;
    int ch;
    q_b.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      ch = i % 2;
      t = 64'h5752_4150_2D30_3030 + 64'(i);
      if (ch == 0) text_b[63:0] = t; else text_b[127:64] = t;
      add_exp(ch, t);
      submit_b(ch == 0 ? 2'b01 : 2'b10);
      wait_b(12*(i+1), 400);
      repeat (5) @(negedge clk);
    end
    checks++;
    if (q_b.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_len: got %0d bytes expected %0d", q_b.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < q_b.size(); i++) begin
      checks++;
      if (q_b[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte[%0d]: got %h expected %h", i, q_b[i], exp_q[i]); end
    end
    checks++;
    if (waddr_b !== 4'd8 || raddr_b !== 4'd8 || drop_b !== 16'd2 || empty_b !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ptrs: aw=%0d ar=%0d drop=%0d empty=%b expected aw=8 ar=8 drop=2 empty=1",
               waddr_b, raddr_b, drop_b, empty_b);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stb_a = '0; stb_b = '0;
    text_a = '0; text_b = '0;
    ext_busy_a = 1'b0; ext_busy_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single_line();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_simultaneous();
    test_backpressure();
    test_reset_mid_write();
    test_overflow();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
